pci_blue_response_fifo: RTL



---
 rtl/pci_blue_response_fifo_pkg.sv | 31 +++
 rtl/pci_blue_fifo_ram.sv | 28 ++
 rtl/pci_blue_response_fifo.sv | 99 +++++++++
 3 files changed

// File: rtl/pci_blue_response_fifo_pkg.sv
// rtl/pci_blue_response_fifo_pkg.sv - response entry encodings and layout
package pci_blue_response_fifo_pkg;

   localparam int ENTRY_W = 40;

   typedef enum logic [3:0] {
      RESP_ADDRESS       = 4'h1,
      RESP_DATA          = 4'h2,
      RESP_DATA_LAST     = 4'h3,
      RESP_WRITE_FENCE   = 4'h4,
      RESP_READ_REQUEST  = 4'h5,
      RESP_MASTER_STATUS = 4'h6
   } resp_type_e;

   typedef struct packed {
      logic [3:0]  rtype;
      logic [3:0]  cbe;
      logic [31:0] data;
   } resp_entry_t;

   function automatic resp_entry_t pack_entry(input logic [3:0] rtype,
                                              input logic [3:0] cbe,
                                              input logic [31:0] data);
      resp_entry_t e;
      e.rtype = rtype;
      e.cbe   = cbe;
      e.data  = data;
      return e;
   endfunction

endpackage

// File: rtl/pci_blue_fifo_ram.sv
// rtl/pci_blue_fifo_ram.sv - register array, one write port, one async read port
module pci_blue_fifo_ram
   import pci_blue_response_fifo_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int WIDTH  = ENTRY_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   // Contents are deliberately left unreset; the pointers decide what is valid.
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pci_blue_response_fifo.sv
// rtl/pci_blue_response_fifo.sv - Target-to-Host response FIFO, first-word-fall-through
module pci_blue_response_fifo
   import pci_blue_response_fifo_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int ADDR_W         = 4,
   parameter int ROOM_THRESHOLD = 2
) (
   input  logic              pci_clk,
   input  logic              pci_reset_l,
   input  logic [3:0]        pci_iface_response_type,
   input  logic [3:0]        pci_iface_response_cbe,
   input  logic [31:0]       pci_iface_response_data,
   input  logic              pci_iface_response_data_load,
   output logic              pci_iface_response_room_available_meta,
   output logic              pci_iface_response_error,
   output logic [3:0]        host_response_type,
   output logic [3:0]        host_response_cbe,
   output logic [31:0]       host_response_data,
   output logic              host_response_data_available,
   input  logic              host_response_unload,
   output logic              host_response_error,
   output logic [ADDR_W:0]   host_response_level
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] THRESH_L = (ADDR_W+1)'(ROOM_THRESHOLD);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              room_q, room_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              full, empty, push, pop;
   resp_entry_t       wr_entry, rd_entry, head;

   always_comb begin
      full     = (level_q == DEPTH_L);
      empty    = (level_q == '0);
      pop      = host_response_unload && !empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the writer.
      push     = pci_iface_response_data_load && (!full || pop);
      wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
      level_d  = level_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
      // Room is judged on next-state level so a writer one cycle behind stays safe.
      room_d   = (DEPTH_L - level_d) >= THRESH_L;
      ovf_d    = ovf_q | (pci_iface_response_data_load && !push);
      unf_d    = unf_q | (host_response_unload && empty);
   end

   always_ff @(posedge pci_clk) begin
      if (!pci_reset_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         room_q   <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         room_q   <= room_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign wr_entry = pack_entry(pci_iface_response_type, pci_iface_response_cbe,
                                pci_iface_response_data);

   pci_blue_fifo_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (ENTRY_W)
   ) u_ram (
      .clk     (pci_clk),
      .wr_en   (push && pci_reset_l),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_entry)
   );

   assign head = empty ? '0 : rd_entry;

   assign host_response_type                     = head.rtype;
   assign host_response_cbe                      = head.cbe;
   assign host_response_data                     = head.data;
   assign host_response_data_available           = !empty;
   assign host_response_level                    = level_q;
   assign pci_iface_response_room_available_meta = room_q;
   assign pci_iface_response_error               = ovf_q;
   assign host_response_error                    = unf_q;

endmodule
